// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for the VGA output path, pixel clock domain.
//   Produces the pixel coordinates, active-high sync, blank and line/frame start
//   markers that the sprite address/colour pipeline consumes. Default timing is
//   1024x768@60 on a 65 MHz pixel clock.
//
// Ports
//   pixel_clk_in     in   1   pixel clock, rising edge
//   rst_n_in         in   1   asynchronous active-low reset
//   en_in            in   1   advance raster when high, freeze when low
//   hcount_out       out  11  pixel column, 0..H_TOTAL-1
//   vcount_out       out  10  line, 0..V_TOTAL-1
//   hsync_out        out  1   high during the horizontal sync interval
//   vsync_out        out  1   high during vertical sync lines (whole lines)
//   blank_out        out  1   high outside the H_ACTIVE x V_ACTIVE region
//   line_start_out   out  1   1-cycle pulse when hcount becomes 0 by wrap
//   frame_start_out  out  1   1-cycle pulse when (h,v) becomes (0,0) by wrap
//
// Every output is a flop. The next coordinates are computed combinationally and
// all decodes are taken from those next coordinates, so sync/blank/pulses always
// describe the coordinates presented in the same cycle.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        en_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        line_start_out,
  output logic        frame_start_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Constants at counter width so every compare is a plain unsigned compare.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en_in) begin
      if (hcount_q == H_LAST) begin
        hcount_d     = 11'd0;
        line_start_d = 1'b1;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end

    // Decodes of the coordinates that will be presented next cycle. When frozen
    // the coordinates do not change, so these simply reproduce the held values.
    hsync_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
    vsync_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
    blank_d = (hcount_d >= H_ACT_END) || (vcount_d >= V_ACT_END);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign blank_out       = blank_q;
  assign line_start_out  = line_start_q;
  assign frame_start_out = frame_start_q;

endmodule
